// File: rtl/sdram_wb_arbiter.sv
// Three-master Wishbone arbiter in front of the SDRAM controller slave port.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed m0 > m1 > m2.
module sdram_wb_arbiter #(
  parameter int ADR_W      = 24,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [2:0]           m_cyc,
  input  logic [2:0]           m_stb,
  input  logic [2:0]           m_we,
  input  logic [3*ADR_W-1:0]   m_adr,
  input  logic [95:0]          m_dat_i,
  input  logic [11:0]          m_sel,
  input  logic [8:0]           m_cti,
  output logic [2:0]           m_ack,
  output logic [31:0]          m_dat_o,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [ADR_W-1:0]     s_adr,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel,
  output logic [2:0]           s_cti,
  input  logic                 s_ack,
  input  logic [31:0]          s_dat_i,
  output logic [2:0]           gnt,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] GAP_LOAD = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

  state_t      r_state, w_next;
  logic [2:0]  r_gnt, w_gnt_nxt;
  logic [1:0]  r_gap_cnt, w_gap_nxt;
  logic [2:0]  w_req;
  logic [2:0]  w_win;
  logic        w_owner_cyc;

  assign w_req       = m_cyc & m_stb;
  assign w_owner_cyc = |(m_cyc & r_gnt);

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] r_last;
  logic [1:0] w_win_idx;

  // Search begins just after the most recently granted master.
  always_comb begin
    w_win = 3'b000;
    case (r_last)
      2'd0: begin
        if (w_req[1]) w_win = 3'b010;
        else if (w_req[2]) w_win = 3'b100;
        else if (w_req[0]) w_win = 3'b001;
      end
      2'd1: begin
        if (w_req[2]) w_win = 3'b100;
        else if (w_req[0]) w_win = 3'b001;
        else if (w_req[1]) w_win = 3'b010;
      end
      default: begin
        if (w_req[0]) w_win = 3'b001;
        else if (w_req[1]) w_win = 3'b010;
        else if (w_req[2]) w_win = 3'b100;
      end
    endcase
  end

  always_comb begin
    w_win_idx = 2'd0;
    if (w_win[1]) w_win_idx = 2'd1;
    if (w_win[2]) w_win_idx = 2'd2;
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_last <= 2'd2;
    end else if (r_state == S_IDLE && |w_req) begin
      r_last <= w_win_idx;
    end
  end
`else
  always_comb begin
    w_win = 3'b000;
    if (w_req[0]) w_win = 3'b001;
    else if (w_req[1]) w_win = 3'b010;
    else if (w_req[2]) w_win = 3'b100;
  end
`endif

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= 3'b000;
      r_gap_cnt <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_gnt     <= w_gnt_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Arbitration happens only in IDLE; the owner keeps the bus until it drops cyc.
  always_comb begin
    w_next    = r_state;
    w_gnt_nxt = r_gnt;
    w_gap_nxt = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_gnt_nxt = w_win;
          w_next    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!w_owner_cyc) begin
          w_gnt_nxt = 3'b000;
          if (GAP_CYCLES > 0) begin
            w_next    = S_GAP;
            w_gap_nxt = GAP_LOAD;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 2'd0) w_next = S_IDLE;
        else w_gap_nxt = r_gap_cnt - 2'd1;
      end
      default: begin
        w_next    = S_IDLE;
        w_gnt_nxt = 3'b000;
      end
    endcase
  end

  // Handshake: a beat completes on a cycle where s_cyc & s_stb & s_ack are all high;
  // the ack is steered combinationally to the owner only, so gnt=0 drops stray acks.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = 32'd0;
    s_sel   = 4'd0;
    s_cti   = 3'd0;
    if (r_state == S_GRANT) begin
      for (int i = 0; i < 3; i++) begin
        if (r_gnt[i]) begin
          s_cyc   = m_cyc[i];
          s_stb   = m_stb[i];
          s_we    = m_we[i];
          s_adr   = m_adr[i*ADR_W +: ADR_W];
          s_dat_o = m_dat_i[i*32 +: 32];
          s_sel   = m_sel[i*4 +: 4];
          s_cti   = m_cti[i*3 +: 3];
        end
      end
    end
  end

  assign m_ack     = {3{s_ack}} & r_gnt;
  assign m_dat_o   = s_dat_i;
  assign gnt       = r_gnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Self-checking bench for sdram_wb_arbiter: reset, priority, burst lock, isolation, mid-transfer reset.
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_sdram_wb_arbiter;
  localparam int ADR_W      = 24;
  localparam int GAP_CYCLES = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [2:0]         m_cyc, m_stb, m_we;
  logic [3*ADR_W-1:0] m_adr;
  logic [95:0]        m_dat_i;
  logic [11:0]        m_sel;
  logic [8:0]         m_cti;
  logic [2:0]         m_ack;
  logic [31:0]        m_dat_o;
  logic               s_cyc, s_stb, s_we;
  logic [ADR_W-1:0]   s_adr;
  logic [31:0]        s_dat_o;
  logic [3:0]         s_sel;
  logic [2:0]         s_cti;
  logic               s_ack;
  logic [31:0]        s_dat_i;
  logic [2:0]         gnt;
  logic [1:0]         dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_d;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sdram_wb_arbiter #(.ADR_W(ADR_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_i(m_dat_i), .m_sel(m_sel), .m_cti(m_cti),
    .m_ack(m_ack), .m_dat_o(m_dat_o),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_sel(s_sel), .s_cti(s_cti),
    .s_ack(s_ack), .s_dat_i(s_dat_i),
    .gnt(gnt), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic set_master(input int idx, input logic cyc, input logic stb, input logic we,
                            input logic [ADR_W-1:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [2:0] cti);
    m_cyc[idx] = cyc;
    m_stb[idx] = stb;
    m_we[idx]  = we;
    m_adr[idx*ADR_W +: ADR_W] = adr;
    m_dat_i[idx*32 +: 32]     = dat;
    m_sel[idx*4 +: 4]         = sel;
    m_cti[idx*3 +: 3]         = cti;
  endtask

  task automatic drop_master(input int idx);
    m_cyc[idx] = 1'b0;
    m_stb[idx] = 1'b0;
  endtask

  task automatic clear_all();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0;
    m_dat_i = '0; m_sel = '0; m_cti = '0;
    s_ack = 1'b0; s_dat_i = '0;
  endtask

  task automatic settle();
    clear_all();
    repeat (GAP_CYCLES + 3) @(negedge clk);
  endtask

  // Slave returns one beat; the data an owner should see is queued now.
  task automatic slave_ack(input logic [31:0] data);
    s_ack   = 1'b1;
    s_dat_i = data;
    exp_q.push_back(data);
  endtask

  // Counts negedges until gnt equals want (bounded by limit).
  task automatic wait_gnt(input logic [2:0] want, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt !== want && n < limit);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    m_cyc = 3'b111; m_stb = 3'b111;
    s_ack = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt, s_cyc, m_ack} !== 7'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: gnt=%b s_cyc=%b m_ack=%b, required all 0", c, gnt, s_cyc, m_ack);
      end
    end
    s_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL reset_release: gnt=%b, required 001", gnt);
    end
    settle();
  endtask

  task automatic test_simultaneous();
    int n;
    set_master(0, 1, 1, 0, 24'h000010, 32'h0, 4'hF, 3'b000);
    set_master(1, 1, 1, 0, 24'h000020, 32'h0, 4'hF, 3'b000);
    set_master(2, 1, 1, 0, 24'h000030, 32'h0, 4'hF, 3'b000);
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL simul_grant: gnt=%b, required 001", gnt);
    end
    slave_ack(32'hA5A5_0001);
    #1;
    checks++;
    if (m_ack !== 3'b001) begin
      errors++;
      $display("FAIL simul_ack: m_ack=%b, required 001", m_ack);
    end
    exp_d = exp_q.pop_front();
    checks++;
    if (m_dat_o !== exp_d) begin
      errors++;
      $display("FAIL simul_rdata: m_dat_o=%h, required %h", m_dat_o, exp_d);
    end
    @(negedge clk);
    s_ack = 1'b0;
    drop_master(0);
    // Drop is sampled at the next edge; the gap lasts GAP_CYCLES, then IDLE grants one edge later.
    wait_gnt(3'b010, 10, n);
    checks++;
    if (gnt !== 3'b010 || n != GAP_CYCLES + 2) begin
      errors++;
      $display("FAIL simul_next: gnt=%b after %0d cycles, required 010 after %0d", gnt, n, GAP_CYCLES + 2);
    end
    settle();
  endtask

  task automatic test_burst_lock();
    int n;
    set_master(2, 1, 1, 0, 24'h000200, 32'h0, 4'hF, 3'b010);
    wait_gnt(3'b100, 10, n);
    checks++;
    if (gnt !== 3'b100 || n != 1) begin
      errors++;
      $display("FAIL burst_grant: gnt=%b after %0d cycles, required 100 after 1", gnt, n);
    end
    for (int b = 0; b < 4; b++) begin
      if (b == 1) set_master(0, 1, 1, 0, 24'h000300, 32'h0, 4'hF, 3'b000);
      if (b == 3) m_cti[8:6] = 3'b111;
      slave_ack(32'hB000_0000 + b);
      #1;
      checks++;
      if (m_ack !== 3'b100 || gnt !== 3'b100) begin
        errors++;
        $display("FAIL burst_beat%0d: m_ack=%b gnt=%b, required 100/100", b, m_ack, gnt);
      end
      exp_d = exp_q.pop_front();
      checks++;
      if (m_dat_o !== exp_d) begin
        errors++;
        $display("FAIL burst_rdata%0d: m_dat_o=%h, required %h", b, m_dat_o, exp_d);
      end
      @(negedge clk);
    end
    s_ack = 1'b0;
    drop_master(2);
    wait_gnt(3'b001, 10, n);
    checks++;
    if (gnt !== 3'b001 || n != GAP_CYCLES + 2) begin
      errors++;
      $display("FAIL burst_handover: gnt=%b after %0d cycles, required 001 after %0d", gnt, n, GAP_CYCLES + 2);
    end
    settle();
  endtask

  task automatic test_isolation();
    int n;
    set_master(0, 1, 0, 0, 24'hFFFFFF, 32'h1111_1111, 4'h3, 3'b111);
    set_master(2, 0, 0, 0, 24'hAAAAAA, 32'h2222_2222, 4'h5, 3'b111);
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== 3'b000) begin
      errors++;
      $display("FAIL cyc_no_stb: gnt=%b, required 000", gnt);
    end
    set_master(1, 1, 1, 1, 24'h000100, 32'hDEAD_BEEF, 4'hC, 3'b000);
    wait_gnt(3'b010, 10, n);
    #1;
    checks++;
    if (gnt !== 3'b010 || {s_cyc, s_stb, s_we} !== 3'b111 || s_adr !== 24'h000100 ||
        s_sel !== 4'hC || s_dat_o !== 32'hDEAD_BEEF || s_cti !== 3'b000) begin
      errors++;
      $display("FAIL m1_write_mux: gnt=%b ctl=%b adr=%h sel=%h dat=%h cti=%b, required 010/111/000100/c/deadbeef/000",
               gnt, {s_cyc, s_stb, s_we}, s_adr, s_sel, s_dat_o, s_cti);
    end
    slave_ack(32'h0000_1234);
    drop_master(1);
    #1;
    checks++;
    if (m_ack !== 3'b010) begin
      errors++;
      $display("FAIL ack_on_drop: m_ack=%b, required 010", m_ack);
    end
    exp_d = exp_q.pop_front();
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    checks++;
    if (m_ack !== 3'b000 || s_cyc !== 1'b0 || gnt !== 3'b000) begin
      errors++;
      $display("FAIL gap_ack_drop: m_ack=%b s_cyc=%b gnt=%b, required 000/0/000", m_ack, s_cyc, gnt);
    end
    s_ack = 1'b0;
    settle();
  endtask

  task automatic test_priority_order();
    int n;
    int idx;
    logic [2:0] want;
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) set_master(i, 1, 1, 0, 24'(16 * (i + 1)), 32'h0, 4'hF, 3'b000);
    for (int t = 0; t < 6; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = t % 3;
`else
      idx = 0;
`endif
      want = 3'b001 << idx;
      wait_gnt(want, 10, n);
      checks++;
      if (gnt !== want) begin
        errors++;
        $display("FAIL order_t%0d: gnt=%b, required %b", t, gnt, want);
      end
      slave_ack(32'hC000_0000 + t);
      #1;
      checks++;
      if (m_ack !== want) begin
        errors++;
        $display("FAIL order_ack_t%0d: m_ack=%b, required %b", t, m_ack, want);
      end
      exp_d = exp_q.pop_front();
      checks++;
      if (m_dat_o !== exp_d) begin
        errors++;
        $display("FAIL order_rdata_t%0d: m_dat_o=%h, required %h", t, m_dat_o, exp_d);
      end
      @(negedge clk);
      s_ack = 1'b0;
      drop_master(idx);
      @(negedge clk);
      m_cyc[idx] = 1'b1;
      m_stb[idx] = 1'b1;
    end
    settle();
  endtask

  task automatic test_mid_reset();
    int n;
    set_master(2, 1, 1, 0, 24'h000400, 32'h0, 4'hF, 3'b010);
    wait_gnt(3'b100, 10, n);
    checks++;
    if (gnt !== 3'b100 || {s_cyc, s_stb} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_pre: gnt=%b cyc/stb=%b, required 100/11", gnt, {s_cyc, s_stb});
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: gnt=%b s_cyc=%b, required 000/0", gnt, s_cyc);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b100 || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL midrst_resume: gnt=%b s_cyc=%b, required 100/1", gnt, s_cyc);
    end
    settle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_all();
    rst_n = 1'b0;
    test_reset();
    test_simultaneous();
    test_burst_lock();
    test_isolation();
    test_priority_order();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
